// File: rtl/logic_unit_seq_pkg.sv
// Shared op codes, mode codes and FSM state encoding for the registered logic unit.
package logic_unit_pkg;
   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_NOTA = 3'd3;
   localparam logic [2:0] OP_NAND = 3'd4;
   localparam logic [2:0] OP_NOR  = 3'd5;
   localparam logic [2:0] OP_XNOR = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;

   localparam logic [1:0] MODE_SINGLE = 2'd0;
   localparam logic [1:0] MODE_ACC    = 2'd1;
   localparam logic [1:0] MODE_SWEEP  = 2'd2;

   typedef enum logic [1:0] {IDLE, HOLD, SWEEP} state_t;
endpackage

// File: rtl/logic_unit_seq_if.sv
// Operand/result handshake bundle between the stimulus front end and the logic unit.
interface logic_unit_seq_if #(parameter int WIDTH = 8);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic [1:0]       mode;
   logic             acc_clr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [2:0]       op_out;
   logic             busy;

   modport master (
      output in_valid, a, b, op, mode, acc_clr, out_ready,
      input  in_ready, out_valid, result, op_out, busy
   );

   modport slave (
      input  in_valid, a, b, op, mode, acc_clr, out_ready,
      output in_ready, out_valid, result, op_out, busy
   );
endinterface

// File: rtl/logic_unit_seq_op.sv
// Purely combinational bitwise operator f(op, a, b); no carries, no width growth.
module logic_op_comb
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = a;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NOTA: y = ~a;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XNOR: y = ~(a ^ b);
         default: y = a;
      endcase
   end

endmodule

// File: rtl/logic_unit_seq.sv
// Registered logic unit with single, accumulate and sweep modes behind a valid/ready handshake.
//   state | meaning
//   IDLE  | no result held, ready for a beat
//   HOLD  | result valid, last beat of the transaction
//   SWEEP | result valid, further sweep beats follow
module logic_unit_seq
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic             clk,
   input logic             rst_n,
   logic_unit_seq_if.slave bus
);

   state_t           state;
   logic [2:0]       cnt;
   logic [2:0]       cnt_nxt;
   logic [WIDTH-1:0] a_lat;
   logic [WIDTH-1:0] b_lat;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] result_q;
   logic [2:0]       op_q;
   logic             accept;
   logic [2:0]       op_sel;
   logic [WIDTH-1:0] opa_sel;
   logic [WIDTH-1:0] opb_sel;
   logic [WIDTH-1:0] f_y;

   assign bus.in_ready  = (state == IDLE) || ((state == HOLD) && bus.out_ready);
   assign accept        = bus.in_valid && bus.in_ready;
   assign cnt_nxt       = cnt + 3'd1;
   assign bus.out_valid = (state != IDLE);
   assign bus.busy      = (state == SWEEP);
   assign bus.result    = result_q;
   assign bus.op_out    = op_q;

   // Sweep can never coincide with an accept (in_ready is low), so one operator serves both.
   always_comb begin
      op_sel  = bus.op;
      opa_sel = bus.a;
      opb_sel = bus.b;
      if (state == SWEEP) begin
         op_sel  = cnt_nxt;
         opa_sel = a_lat;
         opb_sel = b_lat;
      end else if (bus.mode == MODE_SWEEP) begin
         op_sel = OP_AND;
      end else if (bus.mode == MODE_ACC) begin
         opa_sel = bus.acc_clr ? '0 : acc;
      end
   end

   logic_op_comb #(.WIDTH(WIDTH)) u_op (
      .op (op_sel),
      .a  (opa_sel),
      .b  (opb_sel),
      .y  (f_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         a_lat    <= '0;
         b_lat    <= '0;
         acc      <= '0;
         result_q <= '0;
         op_q     <= '0;
      end else begin
         if (accept) begin
            result_q <= f_y;
            op_q     <= op_sel;
            if (bus.mode == MODE_SWEEP) begin
               state <= SWEEP;
               cnt   <= '0;
               a_lat <= bus.a;
               b_lat <= bus.b;
            end else begin
               state <= HOLD;
            end
         end else if ((state == SWEEP) && bus.out_ready) begin
            result_q <= f_y;
            op_q     <= op_sel;
            cnt      <= cnt_nxt;
            if (cnt_nxt == 3'd7) state <= HOLD;
         end else if ((state == HOLD) && bus.out_ready) begin
            state <= IDLE;
         end

         if (accept && (bus.mode == MODE_ACC)) acc <= f_y;
         else if (bus.acc_clr)                 acc <= '0;
      end
   end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Self-checking bench for logic_unit_seq: scoreboard on the 8-bit instance plus directed scenario checks.
module tb_logic_unit_seq;
   import logic_unit_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [10:0] sb_q[$];
   logic [7:0]  mdl_acc = 8'h00;

   always #5 clk = ~clk;

   logic_unit_seq_if #(.WIDTH(8))  u8 ();
   logic_unit_seq_if #(.WIDTH(1))  u1 ();
   logic_unit_seq_if #(.WIDTH(32)) u32 ();

   logic_unit_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(u8));
   logic_unit_seq #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(u1));
   logic_unit_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(u32));

   function automatic logic [31:0] ref_f(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input int w);
      logic [31:0] r;
      logic [31:0] m;
      case (o)
         3'd0:    r = x & y;
         3'd1:    r = x | y;
         3'd2:    r = x ^ y;
         3'd3:    r = ~x;
         3'd4:    r = ~(x & y);
         3'd5:    r = ~(x | y);
         3'd6:    r = ~(x ^ y);
         default: r = x;
      endcase
      m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return r & m;
   endfunction

   // Scoreboard on the 8-bit instance: pop on result transfer, push on beat acceptance.
   always @(negedge clk) begin
      logic [31:0] r;
      logic [7:0]  oa;
      logic [10:0] exp_v;
      if (rst_n) begin
         if (u8.out_valid && u8.out_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_bad++;
               $display("FAIL sb_underflow: got result=%h op=%0d, none expected", u8.result, u8.op_out);
            end else begin
               exp_v = sb_q.pop_front();
               if ({u8.result, u8.op_out} !== exp_v) begin
                  n_bad++;
                  $display("FAIL sb_beat: got result=%h op=%0d, want result=%h op=%0d",
                           u8.result, u8.op_out, exp_v[10:3], exp_v[2:0]);
               end
            end
         end
         if (u8.in_valid && u8.in_ready) begin
            if (u8.mode == MODE_SWEEP) begin
               for (int k = 0; k < 8; k++) begin
                  r = ref_f(3'(k), {24'h0, u8.a}, {24'h0, u8.b}, 8);
                  sb_q.push_back({r[7:0], 3'(k)});
               end
            end else if (u8.mode == MODE_ACC) begin
               oa = u8.acc_clr ? 8'h00 : mdl_acc;
               r = ref_f(u8.op, {24'h0, oa}, {24'h0, u8.b}, 8);
               mdl_acc = r[7:0];
               sb_q.push_back({r[7:0], u8.op});
            end else begin
               r = ref_f(u8.op, {24'h0, u8.a}, {24'h0, u8.b}, 8);
               sb_q.push_back({r[7:0], u8.op});
               if (u8.acc_clr) mdl_acc = 8'h00;
            end
         end else if (u8.acc_clr) begin
            mdl_acc = 8'h00;
         end
      end
   end

   task automatic send(input logic [7:0] a_v, input logic [7:0] b_v, input logic [2:0] op_v,
                       input logic [1:0] mode_v, input logic clr_v);
      int t;
      @(posedge clk); #1;
      u8.a = a_v; u8.b = b_v; u8.op = op_v; u8.mode = mode_v; u8.acc_clr = clr_v;
      u8.in_valid = 1'b1;
      t = 0;
      while (!u8.in_ready && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (!u8.in_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: in_ready=%b after %0d cycles, want 1", u8.in_ready, t);
      end
      @(posedge clk); #1;
      u8.in_valid = 1'b0;
      u8.acc_clr  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_cmp++;
      if ({u8.out_valid, u8.busy, u8.result, u8.op_out} !== 13'h0) begin
         n_bad++;
         $display("FAIL reset_outputs: valid=%b busy=%b result=%h op=%0d, want all 0",
                  u8.out_valid, u8.busy, u8.result, u8.op_out);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (u8.in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_in_ready: got %b want 1", u8.in_ready);
      end
   endtask

   task automatic test_accumulate();
      u8.out_ready = 1'b1;
      send(8'h00, 8'h0F, 3'd1, MODE_ACC, 1'b0);
      n_cmp++;
      if (u8.result !== 8'h0F) begin n_bad++; $display("FAIL acc_first: got %h want 0f", u8.result); end
      send(8'hAA, 8'hFF, 3'd2, MODE_ACC, 1'b0);
      n_cmp++;
      if (u8.result !== 8'hF0) begin n_bad++; $display("FAIL acc_second: got %h want f0", u8.result); end
      send(8'hAA, 8'h55, 3'd1, MODE_ACC, 1'b1);
      n_cmp++;
      if (u8.result !== 8'h55) begin n_bad++; $display("FAIL acc_clr_accept: got %h want 55", u8.result); end
   endtask

   task automatic test_single();
      u8.out_ready = 1'b1;
      send(8'hF0, 8'hCC, 3'd2, MODE_SINGLE, 1'b0);
      n_cmp++;
      if ({u8.out_valid, u8.result, u8.op_out} !== {1'b1, 8'h3C, 3'd2}) begin
         n_bad++;
         $display("FAIL single_xor: valid=%b result=%h op=%0d, want 1 3c 2",
                  u8.out_valid, u8.result, u8.op_out);
      end
   endtask

   task automatic test_sweep();
      logic [7:0] tbl [8];
      tbl = '{8'hC0, 8'hFC, 8'h3C, 8'h0F, 8'h3F, 8'h03, 8'hC3, 8'hF0};
      u8.out_ready = 1'b1;
      send(8'hF0, 8'hCC, 3'd5, MODE_SWEEP, 1'b0);
      for (int k = 0; k < 8; k++) begin
         n_cmp++;
         if ({u8.out_valid, u8.busy, u8.in_ready, u8.result, u8.op_out} !==
             {1'b1, (k < 7) ? 1'b1 : 1'b0, (k == 7) ? 1'b1 : 1'b0, tbl[k], 3'(k)}) begin
            n_bad++;
            $display("FAIL sweep_beat%0d: valid=%b busy=%b in_ready=%b result=%h op=%0d, want result=%h op=%0d",
                     k, u8.out_valid, u8.busy, u8.in_ready, u8.result, u8.op_out, tbl[k], k);
         end
         @(posedge clk); #1;
      end
      n_cmp++;
      if (u8.out_valid !== 1'b0) begin n_bad++; $display("FAIL sweep_done: out_valid=%b want 0", u8.out_valid); end
   endtask

   task automatic test_backpressure();
      u8.out_ready = 1'b0;
      send(8'h12, 8'h34, 3'd0, MODE_SINGLE, 1'b0);
      for (int i = 0; i < 5; i++) begin
         u8.in_valid = 1'b1;
         u8.a = 8'($urandom); u8.b = 8'($urandom); u8.op = 3'($urandom);
         #1;
         n_cmp++;
         if ({u8.out_valid, u8.in_ready, u8.result, u8.op_out} !== {1'b1, 1'b0, 8'h10, 3'd0}) begin
            n_bad++;
            $display("FAIL bp_hold%0d: valid=%b in_ready=%b result=%h op=%0d, want 1 0 10 0",
                     i, u8.out_valid, u8.in_ready, u8.result, u8.op_out);
         end
         @(posedge clk); #1;
      end
      u8.a = 8'hAA; u8.b = 8'h0F; u8.op = 3'd1; u8.mode = MODE_SINGLE;
      u8.out_ready = 1'b1;
      #1;
      n_cmp++;
      if (u8.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", u8.in_ready); end
      @(posedge clk); #1;
      u8.in_valid = 1'b0;
      n_cmp++;
      if ({u8.result, u8.op_out} !== {8'hAF, 3'd1}) begin
         n_bad++;
         $display("FAIL bp_next_beat: result=%h op=%0d, want af 1", u8.result, u8.op_out);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      logic [2:0]  pop;
      u8.out_ready = 1'b1;
      u8.mode = MODE_SINGLE;
      e = '0; pop = '0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (i > 0) begin
            n_cmp++;
            if ({u8.out_valid, u8.result, u8.op_out} !== {1'b1, e[7:0], pop}) begin
               n_bad++;
               $display("FAIL b2b_beat%0d: valid=%b result=%h op=%0d, want 1 %h %0d",
                        i, u8.out_valid, u8.result, u8.op_out, e[7:0], pop);
            end
         end
         if (i < 5) begin
            u8.in_valid = 1'b1;
            u8.a = 8'h5A + 8'(i); u8.b = 8'hC3 ^ 8'(i * 17); u8.op = 3'(i + 3);
            e = ref_f(u8.op, {24'h0, u8.a}, {24'h0, u8.b}, 8);
            pop = u8.op;
         end else begin
            u8.in_valid = 1'b0;
         end
      end
   endtask

   task automatic test_reset_mid_sweep();
      u8.out_ready = 1'b1;
      send(8'hF0, 8'hCC, 3'd0, MODE_SWEEP, 1'b0);
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
      n_cmp++;
      if (u8.op_out !== 3'd3) begin n_bad++; $display("FAIL midsweep_pos: op=%0d want 3", u8.op_out); end
      #2;
      rst_n = 1'b0;
      #1;
      sb_q.delete();
      mdl_acc = 8'h00;
      n_cmp++;
      if ({u8.out_valid, u8.busy, u8.result, u8.op_out} !== 13'h0) begin
         n_bad++;
         $display("FAIL midsweep_reset: valid=%b busy=%b result=%h op=%0d, want all 0",
                  u8.out_valid, u8.busy, u8.result, u8.op_out);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(8'hF0, 8'hCC, 3'd2, MODE_SINGLE, 1'b0);
      n_cmp++;
      if ({u8.out_valid, u8.result, u8.op_out} !== {1'b1, 8'h3C, 3'd2}) begin
         n_bad++;
         $display("FAIL post_reset_single: valid=%b result=%h op=%0d, want 1 3c 2",
                  u8.out_valid, u8.result, u8.op_out);
      end
   endtask

   task automatic test_widths();
      logic [31:0] x1, y1, x32, y32, e1, e32;
      logic [2:0]  o;
      u1.out_ready = 1'b1; u32.out_ready = 1'b1;
      u1.mode = 2'd3; u32.mode = 2'd3;
      for (int i = 0; i < 24; i++) begin
         @(posedge clk); #1;
         o = 3'(i);
         x1 = $urandom; y1 = $urandom; x32 = $urandom; y32 = $urandom;
         u1.a = x1[0:0]; u1.b = y1[0:0]; u1.op = o; u1.in_valid = 1'b1;
         u32.a = x32; u32.b = y32; u32.op = o; u32.in_valid = 1'b1;
         e1 = ref_f(o, {31'h0, x1[0]}, {31'h0, y1[0]}, 1);
         e32 = ref_f(o, x32, y32, 32);
         #1;
         n_cmp++;
         if ({u1.in_ready, u32.in_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL width_ready%0d: w1=%b w32=%b, want 1 1", i, u1.in_ready, u32.in_ready);
         end
         @(posedge clk); #1;
         u1.in_valid = 1'b0; u32.in_valid = 1'b0;
         n_cmp++;
         if ({u1.out_valid, u1.result, u1.op_out} !== {1'b1, e1[0], o}) begin
            n_bad++;
            $display("FAIL width1_op%0d: valid=%b result=%b op=%0d, want 1 %b %0d",
                     o, u1.out_valid, u1.result, u1.op_out, e1[0], o);
         end
         n_cmp++;
         if ({u32.out_valid, u32.result, u32.op_out} !== {1'b1, e32, o}) begin
            n_bad++;
            $display("FAIL width32_op%0d: valid=%b result=%h op=%0d, want 1 %h %0d",
                     o, u32.out_valid, u32.result, u32.op_out, e32, o);
         end
      end
   endtask

   initial begin
      u8.in_valid = 1'b0; u8.a = '0; u8.b = '0; u8.op = '0; u8.mode = '0; u8.acc_clr = 1'b0; u8.out_ready = 1'b0;
      u1.in_valid = 1'b0; u1.a = '0; u1.b = '0; u1.op = '0; u1.mode = '0; u1.acc_clr = 1'b0; u1.out_ready = 1'b0;
      u32.in_valid = 1'b0; u32.a = '0; u32.b = '0; u32.op = '0; u32.mode = '0; u32.acc_clr = 1'b0; u32.out_ready = 1'b0;
      test_reset();
      test_accumulate();
      test_single();
      test_sweep();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_sweep();
      test_widths();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL sb_drain: %0d beats outstanding, want 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
